// File: rtl/epga_spi_pkg.sv
// Shared types and widths for the PLL SPI frame master.
package epga_spi_pkg;

  localparam int SPI_DATA_W  = 24;
  localparam int SPI_DEPTH_W = 8;

  typedef enum logic [2:0] {
    GAP,
    IDLE,
    SETUP,
    HIGH,
    LOW,
    HOLD
  } spi_state_t;

endpackage

// File: rtl/spi_half_tick.sv
// SCLK half-period timer: reloads on load, flags the last cycle of each phase.
module spi_half_tick #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  output logic tick
);

  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)          cnt <= '0;
    else if (load)       cnt <= CW'(CLK_DIV - 1);
    else if (cnt != '0)  cnt <= cnt - CW'(1);
  end

  assign tick = (cnt == '0);

endmodule

// File: rtl/spi_frame_master.sv
// Single-chip SPI master (mode 0): one frame per accepted request, CS rise is the latch strobe.
module spi_frame_master
  import epga_spi_pkg::*;
#(
  parameter int CLK_DIV = 4,
  parameter int CS_GAP  = 4,
  parameter int DATA_W  = SPI_DATA_W
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   spi_start,
  input  logic                   spi_dir,
  input  logic [DATA_W-1:0]      spi_data_tx,
  input  logic [SPI_DEPTH_W-1:0] spi_data_depth,
  output logic                   spi_ready,
  output logic [DATA_W-1:0]      spi_data_rx,
  output logic                   rx_valid,
  output logic                   spi_sclk,
  output logic                   spi_cs_n,
  output logic                   spi_mosi,
  input  logic                   spi_miso
);

  localparam int GW = (CS_GAP > 1) ? $clog2(CS_GAP) : 1;
  localparam logic [SPI_DEPTH_W-1:0] DW = SPI_DEPTH_W'(DATA_W);

  spi_state_t             state, state_nxt;
  logic [GW-1:0]          gap_cnt;
  logic                   armed, dir_q, accept, load, tick, frame_nxt;
  logic [SPI_DEPTH_W-1:0] n_clamp, bits_left;
  logic [DATA_W-1:0]      tx_sh, tx_sh_nxt, rx_sh;

  spi_half_tick #(.CLK_DIV(CLK_DIV)) u_tick (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (load),
    .tick  (tick)
  );

  assign n_clamp = (spi_data_depth > DW) ? DW : spi_data_depth;
  // armed is low on the first IDLE cycle so upstream can swap data under a held start
  assign accept  = (state == IDLE) && armed && spi_start;

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    tx_sh_nxt = tx_sh;
    case (state)
      GAP:   if (gap_cnt == GW'(CS_GAP - 1)) state_nxt = IDLE;
      IDLE:  if (accept) begin
               // left-align so the MSB of the frame is always tx_sh[DATA_W-1]
               tx_sh_nxt = spi_data_tx << (DW - n_clamp);
               if (n_clamp == '0) state_nxt = GAP;
               else begin
                 state_nxt = SETUP;
                 load      = 1'b1;
               end
             end
      SETUP: if (tick) begin
               state_nxt = HIGH;
               load      = 1'b1;
             end
      HIGH:  if (tick) begin
               load = 1'b1;
               if (bits_left == SPI_DEPTH_W'(1)) state_nxt = HOLD;
               else begin
                 state_nxt = LOW;
                 tx_sh_nxt = tx_sh << 1;
               end
             end
      LOW:   if (tick) begin
               state_nxt = HIGH;
               load      = 1'b1;
             end
      HOLD:  if (tick) state_nxt = GAP;
      default: state_nxt = GAP;
    endcase
  end

  assign frame_nxt = (state_nxt == SETUP) || (state_nxt == HIGH) ||
                     (state_nxt == LOW)   || (state_nxt == HOLD);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= GAP;
      gap_cnt     <= '0;
      armed       <= 1'b0;
      dir_q       <= 1'b0;
      bits_left   <= '0;
      tx_sh       <= '0;
      rx_sh       <= '0;
      spi_data_rx <= '0;
      rx_valid    <= 1'b0;
      spi_ready   <= 1'b0;
      spi_sclk    <= 1'b0;
      spi_cs_n    <= 1'b1;
      spi_mosi    <= 1'b0;
    end else begin
      state   <= state_nxt;
      armed   <= (state == IDLE);
      tx_sh   <= tx_sh_nxt;
      gap_cnt <= (state == GAP && state_nxt == GAP) ? gap_cnt + GW'(1) : '0;

      if (accept) begin
        dir_q     <= spi_dir;
        bits_left <= n_clamp;
        rx_sh     <= '0;
      end
      // sample MISO on the edge that raises SCLK
      if (state != HIGH && state_nxt == HIGH) rx_sh <= {rx_sh[DATA_W-2:0], spi_miso};
      if (state == HIGH && tick) bits_left <= bits_left - SPI_DEPTH_W'(1);

      rx_valid <= 1'b0;
      if (state == HOLD && state_nxt == GAP && dir_q) begin
        spi_data_rx <= rx_sh;
        rx_valid    <= 1'b1;
      end

      spi_ready <= (state_nxt == IDLE);
      spi_sclk  <= (state_nxt == HIGH);
      spi_cs_n  <= !frame_nxt;
      spi_mosi  <= frame_nxt ? tx_sh_nxt[DATA_W-1] : 1'b0;
    end
  end

endmodule

// File: tb/tb_spi_frame_master.sv
// Randomized scoreboard bench: driver queues expected frames, bus monitor checks them.
module tb_spi_frame_master;

  localparam int CLK_DIV = 4;
  localparam int CS_GAP  = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        spi_start = 1'b0;
  logic        spi_dir = 1'b0;
  logic [23:0] spi_data_tx = '0;
  logic [7:0]  spi_data_depth = '0;
  logic        spi_ready;
  logic [23:0] spi_data_rx;
  logic        rx_valid;
  logic        spi_sclk;
  logic        spi_cs_n;
  logic        spi_mosi;
  logic        spi_miso = 1'b0;

  spi_frame_master #(.CLK_DIV(CLK_DIV), .CS_GAP(CS_GAP), .DATA_W(24)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .spi_start      (spi_start),
    .spi_dir        (spi_dir),
    .spi_data_tx    (spi_data_tx),
    .spi_data_depth (spi_data_depth),
    .spi_ready      (spi_ready),
    .spi_data_rx    (spi_data_rx),
    .rx_valid       (rx_valid),
    .spi_sclk       (spi_sclk),
    .spi_cs_n       (spi_cs_n),
    .spi_mosi       (spi_mosi),
    .spi_miso       (spi_miso)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [23:0] data;
    int          n;
    bit          dir;
    logic [23:0] rx;
  } exp_t;

  exp_t        sb_q[$];
  logic [23:0] slv_q[$];
  int          checks = 0;
  int          errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  function automatic int clamp_n(input int depth);
    return (depth > 24) ? 24 : depth;
  endfunction

  function automatic logic [23:0] low_mask(input int n);
    logic [31:0] m;
    m = (32'h1 << n) - 32'h1;
    return m[23:0];
  endfunction

  // bus monitor plus a mode-0 slave that shifts MISO out on SCLK falling edges
  logic        pcs = 1'b1, psclk = 1'b0, in_frame = 1'b0, rdy_wait = 1'b0;
  int          low_cnt = 0, mon_nbits = 0, gap_since = 0;
  logic [23:0] mon_bits = '0, slv = '0;
  exp_t        e;

  always @(negedge clk) begin
    if (!rst_n) begin
      in_frame = 1'b0;
      rdy_wait = 1'b0;
      spi_miso = 1'b0;
    end else begin
      if (pcs && !spi_cs_n) begin
        in_frame  = 1'b1;
        low_cnt   = 0;
        mon_bits  = '0;
        mon_nbits = 0;
        slv       = (slv_q.size() != 0) ? slv_q.pop_front() : 24'h0;
        spi_miso  = slv[23];
      end
      if (in_frame && !spi_cs_n) begin
        low_cnt++;
        if (!psclk && spi_sclk) begin
          mon_bits = {mon_bits[22:0], spi_mosi};
          mon_nbits++;
        end
        if (psclk && !spi_sclk) begin
          slv      = slv << 1;
          spi_miso = slv[23];
        end
      end
      if (spi_sclk && !psclk && spi_cs_n) chk("sclk_while_cs_high", 1, 0);
      if (!pcs && spi_cs_n && in_frame) begin
        in_frame = 1'b0;
        spi_miso = 1'b0;
        if (sb_q.size() == 0) chk("frame_expected", 0, 1);
        else begin
          e = sb_q.pop_front();
          chk("mosi_word", {8'h0, mon_bits}, {8'h0, e.data});
          chk("sclk_edges", mon_nbits, e.n);
          chk("cs_low_cycles", low_cnt, (2 * e.n + 1) * CLK_DIV);
          chk("rx_valid_at_cs_rise", {31'h0, rx_valid}, {31'h0, e.dir});
          if (e.dir) chk("rx_data", {8'h0, spi_data_rx}, {8'h0, e.rx});
        end
        rdy_wait  = 1'b1;
        gap_since = 0;
      end else begin
        if (rx_valid) chk("rx_valid_stray", 1, 0);
        if (rdy_wait) begin
          gap_since++;
          if (spi_ready) begin
            chk("cs_rise_to_ready", gap_since, CS_GAP);
            rdy_wait = 1'b0;
          end
        end
      end
    end
    pcs   = spi_cs_n;
    psclk = spi_sclk;
  end

  task automatic wait_ready(output bit ok);
    int t = 0;
    while (!spi_ready && t < 3000) begin
      @(negedge clk);
      t++;
    end
    ok = spi_ready;
    if (!ok) chk("ready_timeout", 0, 1);
  endtask

  // upstream style: start stays high, new word loaded one cycle after ready rises
  task automatic issue(input logic [23:0] d, input int depth, input bit dr, input logic [23:0] mw);
    bit ok;
    int n, t;
    wait_ready(ok);
    if (!ok) return;
    @(negedge clk);
    spi_data_tx    = d;
    spi_data_depth = 8'(depth);
    spi_dir        = dr;
    spi_start      = 1'b1;
    n = clamp_n(depth);
    if (n > 0) begin
      sb_q.push_back('{data: d & low_mask(n), n: n, dir: dr, rx: mw & low_mask(n)});
      slv_q.push_back(mw << (24 - n));
    end
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (spi_ready && t < 10);
    if (spi_ready) begin
      chk("accept_timeout", 0, 1);
      return;
    end
    if (n == 0) begin
      t = 1;
      while (t < 100) begin
        @(negedge clk);
        if (spi_ready) break;
        t++;
      end
      chk("depth0_ready_low_cycles", t, CS_GAP);
    end else begin
      spi_data_tx    = 24'($urandom);
      spi_data_depth = 8'($urandom);
      spi_dir        = 1'($urandom);
    end
  endtask

  task automatic stop_start();
    bit ok;
    wait_ready(ok);
    spi_start = 1'b0;
  endtask

  task automatic do_reset();
    int cnt;
    rst_n     = 1'b0;
    spi_start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_cs_n", {31'h0, spi_cs_n}, 1);
    chk("rst_sclk", {31'h0, spi_sclk}, 0);
    chk("rst_mosi", {31'h0, spi_mosi}, 0);
    chk("rst_ready", {31'h0, spi_ready}, 0);
    chk("rst_rx_valid", {31'h0, rx_valid}, 0);
    chk("rst_data_rx", {8'h0, spi_data_rx}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    cnt = 0;
    while (!spi_ready && cnt < 50) begin
      @(posedge clk);
      #1;
      cnt++;
    end
    chk("reset_to_ready", cnt, CS_GAP);
  endtask

  logic [23:0] words[4] = '{24'h1F8093, 24'h1F8092, 24'h000004, 24'h000A01};

  initial begin
    int t;
    do_reset();

    issue(24'h1F8093, 24, 1'b0, 24'h0);
    foreach (words[i]) issue(words[i], 24, 1'b0, 24'h0);
    issue(24'h00003C, 8, 1'b1, 24'h0000A5);
    issue(24'h123456, 0, 1'b0, 24'h0);
    issue(24'hABCDEF, 30, 1'b0, 24'h0);
    issue(24'h555555, 24, 1'b1, 24'hC3A50F);
    issue(24'h000001, 1, 1'b1, 24'h000001);

    for (int i = 0; i < 20; i++) begin
      int d;
      d = ($urandom_range(0, 7) == 0) ? $urandom_range(0, 255) : $urandom_range(0, 26);
      issue(24'($urandom), d, 1'($urandom), 24'($urandom));
    end
    stop_start();

    t = 0;
    while (sb_q.size() != 0 && t < 5000) begin
      @(negedge clk);
      t++;
    end
    chk("frames_drained", sb_q.size(), 0);

    // abandon a read frame during bit 10
    issue(24'($urandom), 24, 1'b1, 24'($urandom));
    t = 0;
    while (mon_nbits < 10 && t < 3000) begin
      @(negedge clk);
      t++;
    end
    chk("reached_bit10", {31'h0, mon_nbits >= 10}, 1);
    @(posedge clk);
    #2;
    rst_n     = 1'b0;
    spi_start = 1'b0;
    sb_q.delete();
    slv_q.delete();
    #1;
    chk("midframe_rst_cs_n", {31'h0, spi_cs_n}, 1);
    chk("midframe_rst_sclk", {31'h0, spi_sclk}, 0);
    do_reset();
    repeat (300) @(negedge clk);
    chk("no_frames_after_abort", sb_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/spi_frame_master.md
# spi_frame_master

Single-channel SPI master that turns the SPI request interface driven by the control/process stage into serial frames for one PLL chip (ADF4002 or LMX2594). It sits directly downstream of the control FSM, with one instance per chip: bit k of the upstream `spi_start`/`spi_ready` vectors connects to instance k. Chip-select rising edge doubles as the latch-enable strobe. Optional read-back returns MISO data to the upstream stage.

## Interface
- `CLK_DIV`, default 4: system clocks per SCLK half-period; legal range is 1 or more.
- `CS_GAP`, default 4: clocks `spi_cs_n` stays high between frames and after reset; legal range is 1 or more.
- `DATA_W`, default 24: width of the shift registers.
- `clk`  in  1: system clock.
- `rst_n`  in  1: asynchronous, active-low reset.
- `spi_start`  in  1: transfer request, level-sampled.
- `spi_dir`  in  1: 0 = write only; 1 = write and capture MISO.
- `spi_data_tx`  in  24: frame data, right-aligned, sent MSB-first.
- `spi_data_depth`  in  8: number of bits in the frame.
- `spi_ready`  out  1: block is idle and able to accept a request.
- `spi_data_rx`  out  24: captured MISO bits, right-aligned, upper bits zero.
- `rx_valid`  out  1: one-cycle pulse when `spi_data_rx` updates.
- `spi_sclk`  out  1: serial clock, SPI mode 0 (idles low).
- `spi_cs_n`  out  1: chip select / latch enable, active low.
- `spi_mosi`  out  1: serial data out.
- `spi_miso`  in  1: serial data in.

## Operation
- All outputs are registered.
- Reset values: `spi_cs_n`=1, `spi_sclk`=0, `spi_mosi`=0, `spi_ready`=0, `rx_valid`=0, `spi_data_rx`=0. After reset the state is GAP.
- States:
  - GAP: `cs_n`=1. Counts `CS_GAP` cycles, then goes to IDLE.
  - IDLE: `spi_ready`=1.
    - `spi_start` is ignored in the first IDLE cycle (the arm cycle). This lets the upstream stage, which sees `ready`, load new data one cycle later while holding `start` high, without the block resending stale data.
    - From the second IDLE cycle on, `spi_start`=1 accepts a request. On accept: latch `data_tx`, `dir`, and N = min(`depth`, 24); drop `ready` on the next cycle.
    - If N=0: go to GAP with no CS activity.
    - Otherwise go to SETUP.
  - SETUP: `cs_n`=0, `mosi` = bit N-1, `sclk`=0, for `CLK_DIV` cycles.
  - HIGH: `sclk`=1 for `CLK_DIV` cycles. `miso` is sampled on entry.
  - LOW: `sclk`=0 and `mosi` takes the next bit, for `CLK_DIV` cycles. After bit 0, go to HOLD instead.
  - HOLD: `sclk`=0, `cs_n`=0 for `CLK_DIV` cycles. Then `cs_n`=1, go to GAP. If `dir`=1, load `spi_data_rx` and pulse `rx_valid` in the same cycle.
- Depth values above 24 are clamped to 24. Bits above N-1 of `data_tx` are never driven.
- Inputs that change mid-frame have no effect; only the values latched at accept are used.
- Asynchronous reset mid-frame: `cs_n` goes high and `sclk` goes low immediately. The frame is abandoned and the partial RX is discarded.

## Timing
- Accept edge to `cs_n` falling: 1 cycle.
- `cs_n` low duration = (2N+1)·`CLK_DIV` cycles. For N=24 and `CLK_DIV`=4: 196 cycles.
- N rising SCLK edges per frame. The first rising edge occurs `CLK_DIV` cycles after `cs_n` falls.
- `cs_n` rising edge to `ready`=1: `CS_GAP` cycles. The earliest next accept is 1 cycle later (arm cycle).
- For N=0: accept to `ready`=1 takes `CS_GAP`+1 cycles.
- After reset release, `ready` rises after `CS_GAP` cycles.
- `rx_valid` pulses in the same cycle `cs_n` rises.

## Structure
- Package `epga_spi_pkg` contains:
  - the state enum (GAP, IDLE, SETUP, HIGH, LOW, HOLD);
  - `SPI_DATA_W`=24;
  - `SPI_DEPTH_W`=8.
- Sub-module `spi_half_tick`: a `CLK_DIV` down-counter that pulses `tick` at the end of each phase and restarts on a phase-load strobe.
- The main FSM and the TX/RX shift registers live in `spi_frame_master`.

## Test plan
- Reset: hold `rst_n`=0, release. `cs_n`=1 and `sclk`=0 throughout; `ready` rises exactly `CS_GAP`=4 cycles after release.
- Write `24'h1F8093`, depth 24, `CLK_DIV`=4: the 24 MOSI bits sampled on SCLK rising edges reconstruct `0x1F8093`; `cs_n` is low for 196 cycles; `ready` returns 4 cycles after `cs_n` rises.
- Upstream-style sequencing: hold `start`=1 and load a new word one cycle after each `ready` rise, for words `0x1F8093`, `0x1F8092`, `0x000004`, `0x000A01`. Exactly four frames are sent, each word once, in order.
- Read: `dir`=1, depth 8, MISO drives `0xA5` MSB-first. `spi_data_rx`=`24'h0000A5` and `rx_valid` is high for exactly 1 cycle.
- Depth 0: no SCLK edges and `cs_n` stays 1. Depth 30 with `data`=`0xABCDEF`: exactly 24 edges and `0xABCDEF` is sent.
- Assert `rst_n`=0 during bit 10: `cs_n`=1 before the next clock edge, no further SCLK edges, `rx_valid` never pulses.
